// File: rtl/cpu_bus_master.sv
// CPU-side master for the C1/A1/D1 cache bus: one request at a time, two-cycle command/address phase, response gather.
// Optional statistics counters are enabled by defining CPU_BUS_STATS_EN.
module cpu_bus_master #(
    parameter int CACHE_ADDR_SIZE   = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int DATA_BUS_SIZE     = 16,
    parameter int CTR1_BUS_SIZE     = 3,
    parameter int TIMEOUT           = 255
) (
`ifdef CPU_BUS_STATS_EN
    output logic [31:0]                 stat_reqs,
    output logic [31:0]                 stat_wait_cycles,
    output logic [15:0]                 stat_timeouts,
`endif
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_op,
    input  logic [CACHE_ADDR_SIZE-1:0]  req_addr,
    input  logic [31:0]                 req_wdata,
    output logic                        rsp_valid,
    output logic [31:0]                 rsp_rdata,
    output logic                        rsp_err,
    output tri   [ADDR1_BUS_SIZE-1:0]   A1,
    inout  tri   [DATA_BUS_SIZE-1:0]    D1,
    inout  tri   [CTR1_BUS_SIZE-1:0]    C1
);

    localparam logic [2:0] OP_READ8   = 3'd1;
    localparam logic [2:0] OP_READ16  = 3'd2;
    localparam logic [2:0] OP_READ32  = 3'd3;
    localparam logic [2:0] OP_WRITE8  = 3'd5;
    localparam logic [2:0] OP_WRITE16 = 3'd6;
    localparam logic [2:0] OP_WRITE32 = 3'd7;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CMD1, CMD2, WAIT, BEAT2, RESP} state_t;

    state_t                     state_q, state_d;
    logic [2:0]                 op_q, op_d;
    logic [CACHE_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [15:0]                b1_q, b1_d;
    logic [31:0]                rdata_q, rdata_d;
    logic                       err_q, err_d;
    logic                       timeoutHit;

    logic [CTR1_BUS_SIZE-1:0]   busC1_q, busC1_d;
    logic [ADDR1_BUS_SIZE-1:0]  busA1_q, busA1_d;
    logic [DATA_BUS_SIZE-1:0]   busD1_q, busD1_d;
    logic                       busC1En_q, busC1En_d;
    logic                       busA1En_q, busA1En_d;
    logic                       busD1En_q, busD1En_d;
    logic [15:0]                beat1, beat2;
    logic                       isWrite;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign C1 = busC1En_q ? busC1_q : {CTR1_BUS_SIZE{1'bz}};
    assign A1 = busA1En_q ? busA1_q : {ADDR1_BUS_SIZE{1'bz}};
    assign D1 = busD1En_q ? busD1_q : {DATA_BUS_SIZE{1'bz}};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            b1_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            b1_q    <= b1_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // A response seen on the same edge as the timeout wins over the timeout.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        b1_d       = b1_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        timeoutHit = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (req_op == 3'd0) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = CMD1;
                    end
                end
            end
            CMD1: state_d = CMD2;
            CMD2: state_d = WAIT;
            WAIT: begin
                if (C1 == CTR1_BUS_SIZE'(7)) begin
                    b1_d = 16'(D1);
                    if (op_q == OP_READ32) begin
                        state_d = BEAT2;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b0;
                        case (op_q)
                            OP_READ8:  rdata_d = {24'b0, D1[7:0]};
                            OP_READ16: rdata_d = {16'b0, D1[7:0], D1[15:8]};
                            default:   rdata_d = '0;
                        endcase
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = RESP;
                    err_d      = 1'b1;
                    rdata_d    = '0;
                    timeoutHit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BEAT2: begin
                state_d = RESP;
                err_d   = 1'b0;
                rdata_d = {b1_q[7:0], b1_q[15:8], D1[7:0], D1[15:8]};
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus drive values follow the posedge state and are registered on negedge for a stable cache sample.
    always_comb begin
        isWrite = (op_q == OP_WRITE8) || (op_q == OP_WRITE16) || (op_q == OP_WRITE32);
        case (op_q)
            OP_WRITE8:  beat1 = {8'b0, wdata_q[7:0]};
            OP_WRITE16: beat1 = {wdata_q[7:0], wdata_q[15:8]};
            default:    beat1 = {wdata_q[23:16], wdata_q[31:24]};
        endcase
        beat2     = {wdata_q[7:0], wdata_q[15:8]};
        busC1_d   = CTR1_BUS_SIZE'(op_q);
        busA1_d   = '0;
        busD1_d   = '0;
        busC1En_d = 1'b0;
        busA1En_d = 1'b0;
        busD1En_d = 1'b0;
        if (state_q == CMD1) begin
            busC1En_d = 1'b1;
            busA1En_d = 1'b1;
            busD1En_d = isWrite;
            busA1_d   = ADDR1_BUS_SIZE'(addr_q[CACHE_ADDR_SIZE-1:CACHE_OFFSET_SIZE]);
            busD1_d   = DATA_BUS_SIZE'(beat1);
        end else if (state_q == CMD2) begin
            busC1En_d = 1'b1;
            busA1En_d = 1'b1;
            busD1En_d = isWrite;
            busA1_d   = ADDR1_BUS_SIZE'(addr_q[CACHE_OFFSET_SIZE-1:0]);
            busD1_d   = DATA_BUS_SIZE'((op_q == OP_WRITE32) ? beat2 : beat1);
        end
    end

    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            busC1_q   <= '0;
            busA1_q   <= '0;
            busD1_q   <= '0;
            busC1En_q <= 1'b0;
            busA1En_q <= 1'b0;
            busD1En_q <= 1'b0;
        end else begin
            busC1_q   <= busC1_d;
            busA1_q   <= busA1_d;
            busD1_q   <= busD1_d;
            busC1En_q <= busC1En_d;
            busA1En_q <= busA1En_d;
            busD1En_q <= busD1En_d;
        end
    end

`ifdef CPU_BUS_STATS_EN
    logic [31:0] statReqs_q, statWait_q;
    logic [15:0] statTimeouts_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            statReqs_q     <= '0;
            statWait_q     <= '0;
            statTimeouts_q <= '0;
        end else begin
            if (state_q == IDLE && req_valid && statReqs_q != '1)
                statReqs_q <= statReqs_q + 32'd1;
            if (state_q == WAIT && statWait_q != '1)
                statWait_q <= statWait_q + 32'd1;
            if (timeoutHit && statTimeouts_q != '1)
                statTimeouts_q <= statTimeouts_q + 16'd1;
        end
    end

    assign stat_reqs        = statReqs_q;
    assign stat_wait_cycles = statWait_q;
    assign stat_timeouts    = statTimeouts_q;
`endif

endmodule
